// File: rtl/rv_execute_stage_if.sv
// Execute-stage bus: ID/EX inputs, forwarding sources and EX results.
// slave = the execute stage, master = whoever drives decode/forwarding.
interface rv_execute_stage_if #(
  parameter int XLEN = 32
);
  logic            load, flush;
  logic [XLEN-1:0] pc_in, rs1_in, rs2_in, imm_in, tgtaddr_in;
  logic [4:0]      rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic [6:0]      opcode_in;
  logic [2:0]      funct3_in;
  logic            funct7b5_in, load_regfile_in, br_predict_in;
  logic [1:0]      forward_a, forward_b;
  logic [XLEN-1:0] wb_data, mem_alu, mem_rdata;

  logic [XLEN-1:0] pc_out, alu_out, rs2_out, pc_next, pc_plus4_out;
  logic [4:0]      rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [6:0]      opcode_out;
  logic [2:0]      funct3_out;
  logic            load_regfile_out, mem_read_out, mem_write_out;
  logic            br_en, jump_en, mispredict;
  logic [9:0]      perf_mispredicts, perf_branches;

  modport slave (
    input  load, flush, pc_in, rs1_in, rs2_in, imm_in, tgtaddr_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in, opcode_in, funct3_in,
           funct7b5_in, load_regfile_in, br_predict_in,
           forward_a, forward_b, wb_data, mem_alu, mem_rdata,
    output pc_out, alu_out, rs2_out, pc_next, pc_plus4_out,
           rs1_addr_out, rs2_addr_out, rd_addr_out, opcode_out, funct3_out,
           load_regfile_out, mem_read_out, mem_write_out,
           br_en, jump_en, mispredict, perf_mispredicts, perf_branches
  );

  modport master (
    output load, flush, pc_in, rs1_in, rs2_in, imm_in, tgtaddr_in,
           rs1_addr_in, rs2_addr_in, rd_addr_in, opcode_in, funct3_in,
           funct7b5_in, load_regfile_in, br_predict_in,
           forward_a, forward_b, wb_data, mem_alu, mem_rdata,
    input  pc_out, alu_out, rs2_out, pc_next, pc_plus4_out,
           rs1_addr_out, rs2_addr_out, rd_addr_out, opcode_out, funct3_out,
           load_regfile_out, mem_read_out, mem_write_out,
           br_en, jump_en, mispredict, perf_mispredicts, perf_branches
  );
endinterface

// File: rtl/rv_execute_stage.sv
// RV32I execute stage: ID/EX register, forwarding muxes, ALU, branch resolution.
// Define EX_PERF_CNT_EN to add 10-bit mispredict/branch event counters.
module rv_execute_stage #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  rv_execute_stage_if.slave ex
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc, pc4, rs1, rs2, imm, tgt;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b5, load_regfile, br_predict, mem_read, mem_write;
  } idex_t;

  idex_t d, q;

  always_comb begin
    d              = '0;
    d.pc           = ex.pc_in;
    d.pc4          = ex.pc_in + XLEN'(4);
    d.rs1          = ex.rs1_in;
    d.rs2          = ex.rs2_in;
    d.imm          = ex.imm_in;
    d.tgt          = ex.tgtaddr_in;
    d.rs1_addr     = ex.rs1_addr_in;
    d.rs2_addr     = ex.rs2_addr_in;
    d.rd_addr      = ex.rd_addr_in;
    d.opcode       = ex.opcode_in;
    d.funct3       = ex.funct3_in;
    d.f7b5         = ex.funct7b5_in;
    d.load_regfile = ex.load_regfile_in;
    d.br_predict   = ex.br_predict_in;
    d.mem_read     = (ex.opcode_in == OPC_LOAD);
    d.mem_write    = (ex.opcode_in == OPC_STORE);
  end

  // All-zero is the bubble encoding (opcode 0, no writes, no memory op).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q <= '0;
    else if (ex.load) q <= ex.flush ? '0 : d;
  end

  assign ex.pc_out           = q.pc;
  assign ex.pc_plus4_out     = q.pc4;
  assign ex.rs1_addr_out     = q.rs1_addr;
  assign ex.rs2_addr_out     = q.rs2_addr;
  assign ex.rd_addr_out      = q.rd_addr;
  assign ex.opcode_out       = q.opcode;
  assign ex.funct3_out       = q.funct3;
  assign ex.load_regfile_out = q.load_regfile;
  assign ex.mem_read_out     = q.mem_read;
  assign ex.mem_write_out    = q.mem_write;

  logic [XLEN-1:0] fa, fb;

  // x0 reads as zero even if a stale forward select points elsewhere.
  always_comb begin
    fa = '0;
    fb = '0;
    case (ex.forward_a)
      2'd0:    fa = q.rs1;
      2'd1:    fa = ex.wb_data;
      2'd2:    fa = ex.mem_alu;
      default: fa = ex.mem_rdata;
    endcase
    case (ex.forward_b)
      2'd0:    fb = q.rs2;
      2'd1:    fb = ex.wb_data;
      2'd2:    fb = ex.mem_alu;
      default: fb = ex.mem_rdata;
    endcase
    if (q.rs1_addr == 5'd0) fa = '0;
    if (q.rs2_addr == 5'd0) fb = '0;
  end

  logic            is_op;
  logic [XLEN-1:0] opb, alu_res, addr_sum, pc_imm;
  logic [4:0]      shamt;

  assign is_op    = (q.opcode == OPC_OP);
  assign opb      = is_op ? fb : q.imm;
  assign shamt    = opb[4:0];
  assign addr_sum = fa + q.imm;
  assign pc_imm   = q.pc + q.imm;

  always_comb begin
    alu_res = '0;
    case (q.funct3)
      3'b000:  alu_res = (is_op && q.f7b5) ? fa - opb : fa + opb;
      3'b001:  alu_res = fa << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(opb)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, fa < opb};
      3'b100:  alu_res = fa ^ opb;
      3'b101:  alu_res = q.f7b5 ? $unsigned($signed(fa) >>> shamt) : fa >> shamt;
      3'b110:  alu_res = fa | opb;
      default: alu_res = fa & opb;
    endcase
  end

  always_comb begin
    ex.alu_out = '0;
    case (q.opcode)
      OPC_OP, OPC_OPIMM:   ex.alu_out = alu_res;
      OPC_LOAD, OPC_STORE: ex.alu_out = addr_sum;
      OPC_LUI:             ex.alu_out = q.imm;
      OPC_AUIPC:           ex.alu_out = pc_imm;
      OPC_JAL, OPC_JALR:   ex.alu_out = q.pc4;
      default:             ex.alu_out = '0;
    endcase
  end

  assign ex.rs2_out = fb;

  logic cond, taken;

  always_comb begin
    cond = 1'b0;
    case (q.funct3)
      3'b000:  cond = (fa == fb);
      3'b001:  cond = (fa != fb);
      3'b100:  cond = ($signed(fa) < $signed(fb));
      3'b101:  cond = !($signed(fa) < $signed(fb));
      3'b110:  cond = (fa < fb);
      3'b111:  cond = !(fa < fb);
      default: cond = 1'b0;
    endcase
  end

  assign ex.br_en   = (q.opcode == OPC_BRANCH) && cond;
  assign ex.jump_en = (q.opcode == OPC_JAL) || (q.opcode == OPC_JALR);
  assign taken      = ex.br_en || ex.jump_en;

  always_comb begin
    ex.pc_next = q.pc + XLEN'(4);
    if (q.opcode == OPC_JALR)
      ex.pc_next = {addr_sum[XLEN-1:1], 1'b0};
    else if (ex.br_en || q.opcode == OPC_JAL)
      ex.pc_next = pc_imm;
  end

  // A correctly predicted direction still mispredicts if the target was wrong.
  assign ex.mispredict = (taken != q.br_predict) ||
                         (taken && q.br_predict && (q.tgt != ex.pc_next));

`ifdef EX_PERF_CNT_EN
  logic [9:0] n_misp, n_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_misp <= '0;
      n_br   <= '0;
    end else if (ex.load) begin
      if (ex.mispredict) n_misp <= n_misp + 10'd1;
      if (ex.br_en)      n_br   <= n_br + 10'd1;
    end
  end

  assign ex.perf_mispredicts = n_misp;
  assign ex.perf_branches    = n_br;
`else
  assign ex.perf_mispredicts = '0;
  assign ex.perf_branches    = '0;
`endif

endmodule

// File: tb/tb_rv_execute_stage.sv
// Directed + random bench for rv_execute_stage against an instruction-level model.
module tb_rv_execute_stage;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
`ifdef EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_execute_stage_if #(.XLEN(32)) ex_if ();
  rv_execute_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .ex(ex_if));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: the instruction currently sitting in EX, as plain fields.
  logic [31:0] m_pc, m_pc4, m_rs1, m_rs2, m_imm, m_tgt;
  logic [4:0]  m_ra, m_rb, m_rd;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7, m_lr, m_bp;
  logic [9:0]  m_nmisp, m_nbr;

  typedef struct {
    logic [31:0] alu, rs2, pcn;
    logic        br, jmp, misp;
  } exp_t;

  task automatic model_bubble();
    {m_pc, m_pc4, m_rs1, m_rs2, m_imm, m_tgt} = '0;
    {m_ra, m_rb, m_rd, m_op, m_f3, m_f7, m_lr, m_bp} = '0;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [4:0] a, input logic [31:0] v);
    if (a == 5'd0) return 32'd0;
    case (s)
      2'd0:    return v;
      2'd1:    return ex_if.wb_data;
      2'd2:    return ex_if.mem_alu;
      default: return ex_if.mem_rdata;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub, input logic ari,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b % 32;
    fill = (a[31] && ari) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (f3)
      3'd0:    return sub ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return (a >> sh) | fill;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic [31:0] a, b, seq, tgt;
    logic take, lt, ltu;
    a = fwd(ex_if.forward_a, m_ra, m_rs1);
    b = fwd(ex_if.forward_b, m_rb, m_rs2);
    seq = m_pc + 32'd4;
    tgt = m_pc + m_imm;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    e.rs2 = b; e.alu = 32'd0; e.pcn = seq; e.br = 1'b0; e.jmp = 1'b0;
    case (m_op)
      OP:      e.alu = alu_ref(m_f3, m_f7, m_f7, a, b);
      OPI:     e.alu = alu_ref(m_f3, 1'b0, m_f7, a, m_imm);
      LD, ST:  e.alu = a + m_imm;
      LUI:     e.alu = m_imm;
      AUIPC:   e.alu = tgt;
      JAL:     begin e.alu = seq; e.jmp = 1'b1; e.pcn = tgt; end
      JALR:    begin e.alu = seq; e.jmp = 1'b1; e.pcn = (a + m_imm) & ~32'd1; end
      BR: begin
        case (m_f3)
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = lt;
          3'd5: e.br = !lt;
          3'd6: e.br = ltu;
          3'd7: e.br = !ltu;
          default: e.br = 1'b0;
        endcase
        if (e.br) e.pcn = tgt;
      end
      default: ;
    endcase
    take = e.br || e.jmp;
    e.misp = (take != m_bp) || (take && m_bp && (m_tgt != e.pcn));
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    e = model_eval();
    if (ex_if.load) begin
      if (e.misp) m_nmisp = m_nmisp + 10'd1;
      if (e.br)   m_nbr   = m_nbr + 10'd1;
      if (ex_if.flush) model_bubble();
      else begin
        m_pc = ex_if.pc_in; m_pc4 = ex_if.pc_in + 32'd4;
        m_rs1 = ex_if.rs1_in; m_rs2 = ex_if.rs2_in; m_imm = ex_if.imm_in; m_tgt = ex_if.tgtaddr_in;
        m_ra = ex_if.rs1_addr_in; m_rb = ex_if.rs2_addr_in; m_rd = ex_if.rd_addr_in;
        m_op = ex_if.opcode_in; m_f3 = ex_if.funct3_in; m_f7 = ex_if.funct7b5_in;
        m_lr = ex_if.load_regfile_in; m_bp = ex_if.br_predict_in;
      end
    end
    #1;
  endtask

  task automatic check_all(input string p);
    exp_t e;
    e = model_eval();
    chk({p, ".alu"}, ex_if.alu_out, e.alu);
    chk({p, ".rs2"}, ex_if.rs2_out, e.rs2);
    chk({p, ".pcn"}, ex_if.pc_next, e.pcn);
    chk({p, ".br"}, ex_if.br_en, e.br);
    chk({p, ".jmp"}, ex_if.jump_en, e.jmp);
    chk({p, ".misp"}, ex_if.mispredict, e.misp);
    chk({p, ".pc"}, ex_if.pc_out, m_pc);
    chk({p, ".pc4"}, ex_if.pc_plus4_out, m_pc4);
    chk({p, ".addr"}, {ex_if.rs1_addr_out, ex_if.rs2_addr_out, ex_if.rd_addr_out}, {m_ra, m_rb, m_rd});
    chk({p, ".opc"}, {ex_if.opcode_out, ex_if.funct3_out}, {m_op, m_f3});
    chk({p, ".lr"}, ex_if.load_regfile_out, m_lr);
    chk({p, ".mrw"}, {ex_if.mem_read_out, ex_if.mem_write_out}, {m_op == LD, m_op == ST});
    chk({p, ".pmis"}, ex_if.perf_mispredicts, PERF ? m_nmisp : 10'd0);
    chk({p, ".pbr"}, ex_if.perf_branches, PERF ? m_nbr : 10'd0);
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc);
    ex_if.opcode_in = op; ex_if.funct3_in = f3; ex_if.funct7b5_in = f7;
    ex_if.rs1_addr_in = ra; ex_if.rs2_addr_in = rb; ex_if.rd_addr_in = rd;
    ex_if.rs1_in = v1; ex_if.rs2_in = v2; ex_if.imm_in = imm; ex_if.pc_in = pc;
    ex_if.load_regfile_in = (op != BR) && (op != ST);
    ex_if.br_predict_in = 1'b0; ex_if.tgtaddr_in = 32'd0;
    ex_if.forward_a = 2'd0; ex_if.forward_b = 2'd0;
    ex_if.load = 1'b1; ex_if.flush = 1'b0;
  endtask

  task automatic rnd_id();
    logic [6:0] ops [9];
    logic [31:0] pc, imm;
    ops = '{OP, OPI, LD, ST, BR, JAL, JALR, LUI, AUIPC};
    pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
    set_id(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
           3'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           5'($urandom), $urandom, $urandom, imm, pc);
    if ($urandom_range(0, 3) == 0) ex_if.rs2_in = ex_if.rs1_in;
    ex_if.br_predict_in = 1'($urandom);
    ex_if.tgtaddr_in = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom;
    ex_if.load = ($urandom_range(0, 7) != 0);
    ex_if.flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    ex_if.load = 1'b0;
    ex_if.wb_data = 32'd0; ex_if.mem_alu = 32'd0; ex_if.mem_rdata = 32'd0;
    model_bubble(); m_nmisp = '0; m_nbr = '0;
    #12;
    chk("rst.opc", ex_if.opcode_out, 32'd0);
    chk("rst.pc", ex_if.pc_out, 32'd0);
    chk("rst.flags", {ex_if.load_regfile_out, ex_if.mem_read_out, ex_if.mem_write_out,
                      ex_if.br_en, ex_if.jump_en, ex_if.mispredict}, 32'd0);
    check_all("rst");
    rst_n = 1'b1;

    set_id(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h10);
    tick();
    chk("add.alu", ex_if.alu_out, 32'd12);
    chk("add.br", ex_if.br_en, 32'd0);
    chk("add.rd", ex_if.rd_addr_out, 32'd3);
    chk("add.lr", ex_if.load_regfile_out, 32'd1);
    check_all("add");

    set_id(OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 32'h14);
    tick(); chk("sub.alu", ex_if.alu_out, 32'hFFFF_FFFF); check_all("sub");
    set_id(OP, 3'd5, 1'b1, 5'd1, 5'd2, 5'd4, 32'h8000_0000, 32'd4, 32'd0, 32'h18);
    tick(); chk("sra.alu", ex_if.alu_out, 32'hF800_0000); check_all("sra");
    set_id(OP, 3'd3, 1'b0, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1C);
    tick(); chk("sltu.alu", ex_if.alu_out, 32'd0); check_all("sltu");

    set_id(OPI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd1, 32'h20);
    ex_if.forward_a = 2'd2; ex_if.mem_alu = 32'h100;
    tick(); chk("fwd.alu", ex_if.alu_out, 32'h101); check_all("fwd");
    ex_if.rs1_addr_in = 5'd0;
    tick(); chk("x0.alu", ex_if.alu_out, 32'd1); check_all("x0");

    set_id(BR, 3'd4, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h40);
    tick();
    chk("blt.br", ex_if.br_en, 32'd1);
    chk("blt.pcn", ex_if.pc_next, 32'h38);
    chk("blt.misp", ex_if.mispredict, 32'd1);
    check_all("blt");
    ex_if.br_predict_in = 1'b1; ex_if.tgtaddr_in = 32'h38;
    tick(); chk("bltp.misp", ex_if.mispredict, 32'd0); check_all("bltp");

    set_id(JALR, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1, 32'h205, 32'd0, 32'd0, 32'h100);
    tick();
    chk("jalr.pcn", ex_if.pc_next, 32'h204);
    chk("jalr.alu", ex_if.alu_out, 32'h104);
    chk("jalr.jmp", ex_if.jump_en, 32'd1);
    check_all("jalr");

    set_id(ST, 3'd2, 1'b0, 5'd6, 5'd7, 5'd0, 32'h1000, 32'hAB, 32'd8, 32'h200);
    ex_if.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold.pc", ex_if.pc_out, 32'h100);
      chk("hold.opc", ex_if.opcode_out, {25'd0, JALR});
      check_all("hold");
    end

    ex_if.load = 1'b1;
    tick(); chk("st.mw", ex_if.mem_write_out, 32'd1); check_all("st");
    ex_if.flush = 1'b1;
    tick();
    chk("flush.mw", ex_if.mem_write_out, 32'd0);
    chk("flush.br", ex_if.br_en, 32'd0);
    chk("flush.opc", ex_if.opcode_out, 32'd0);
    check_all("flush");
    ex_if.flush = 1'b0;

    set_id(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 32'h300);
    tick();
    ex_if.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.opc", ex_if.opcode_out, 32'd0);
    chk("arst.pc", ex_if.pc_out, 32'd0);
    chk("arst.lr", ex_if.load_regfile_out, 32'd0);
    model_bubble(); m_nmisp = '0; m_nbr = '0;
    check_all("arst");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      rnd_id();
      tick();
      ex_if.forward_a = 2'($urandom); ex_if.forward_b = 2'($urandom);
      ex_if.wb_data = $urandom; ex_if.mem_alu = $urandom;
      ex_if.mem_rdata = ($urandom_range(0, 3) == 0) ? ex_if.wb_data : $urandom;
      #1;
      check_all("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
